// File: rtl/riscv_pkg.sv
// Shared constants and FSM encoding for the riscv instruction-fetch slice.
package riscv_pkg;

  localparam int XLEN_DEF = 32;
  localparam int INSN_W   = 32;
  localparam logic [INSN_W-1:0] INSN_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue: entries are allocated at request time, filled as
// responses return, and released from the head once the core takes them.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int FQ_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      alloc,
  input  logic [XLEN-1:0]           alloc_pc,
  input  logic                      fill,
  input  logic [INSN_W-1:0]         fill_data,
  input  logic                      deq,
  output logic                      head_valid,
  output logic [XLEN-1:0]           head_pc,
  output logic [INSN_W-1:0]         head_data,
  output logic [$clog2(FQ_DEPTH):0] used,
  output logic [$clog2(FQ_DEPTH):0] unfilled
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0]     pc_q   [FQ_DEPTH];
  logic [INSN_W-1:0]   data_q [FQ_DEPTH];
  logic [FQ_DEPTH-1:0] filled;
  logic [PW-1:0]       wr_ptr, fill_ptr, rd_ptr;
  logic [CW-1:0]       cnt, unf;

  // Control: pointers, occupancy and filled flags. Responses return in
  // order, so fill_ptr always names the oldest unfilled entry.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      unf      <= '0;
      filled   <= '0;
    end else begin
      if (alloc) begin
        wr_ptr         <= wr_ptr + 1'b1;
        filled[wr_ptr] <= 1'b0;
      end
      if (fill) begin
        fill_ptr         <= fill_ptr + 1'b1;
        filled[fill_ptr] <= 1'b1;
      end
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(alloc) - CW'(deq);
      unf <= unf + CW'(alloc) - CW'(fill);
    end
  end

  // Payload storage carries no reset; it is only observed behind head_valid.
  always_ff @(posedge clk) begin
    if (alloc) pc_q[wr_ptr]     <= alloc_pc;
    if (fill)  data_q[fill_ptr] <= fill_data;
  end

  assign head_valid = (cnt != '0) && filled[rd_ptr];
  assign head_pc    = pc_q[rd_ptr];
  assign head_data  = data_q[rd_ptr];
  assign used       = cnt;
  assign unfilled   = unf;

endmodule

// File: rtl/riscv_fetch.sv
// riscv_fetch: PC owner, imem request issue with credit/drop accounting, and
// fetch-queue handoff to the core. FETCH_MISALIGN_CHK_EN adds the TRAP path.
module riscv_fetch
  import riscv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              FQ_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INSN_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INSN_W-1:0] inst_data,
  output logic [XLEN-1:0]   inst_pc
`ifdef FETCH_MISALIGN_CHK_EN
  , output logic            inst_misaligned
`endif
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  fetch_state_e    state, state_nx;
  logic [XLEN-1:0] pc;
  logic [CW-1:0]   drop_cnt;
  logic [XLEN-1:0] tgt;
  logic            misalign;
  logic            trap_show;
  logic            q_head_valid;
  logic [XLEN-1:0] q_head_pc;
  logic [INSN_W-1:0] q_head_data;
  logic [CW-1:0]   used, unfilled, used_eff;
  logic            q_deq, req_fire, fill;

`ifdef FETCH_MISALIGN_CHK_EN
  logic trap_pend;

  assign tgt       = redirect_pc;
  assign misalign  = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign trap_show = (state == ST_TRAP) && trap_pend && (drop_cnt == '0);
  assign inst_misaligned = trap_show && !q_head_valid;

  always_ff @(posedge clk) begin
    if (rst)                          trap_pend <= 1'b0;
    else if (redirect_valid)          trap_pend <= misalign;
    else if (trap_show && inst_ready) trap_pend <= 1'b0;
  end
`else
  assign tgt       = redirect_pc & ~XLEN'(3);
  assign misalign  = 1'b0;
  assign trap_show = 1'b0;
`endif

  assign q_deq      = q_head_valid && inst_ready;
  // A head entry leaving this cycle counts as free, so full-rate fetch can
  // recycle its slot in the same cycle.
  assign used_eff   = used - CW'(q_deq);
  assign imem_req_valid = (state == ST_RUN) && !redirect_valid &&
                          (({1'b0, used_eff} + {1'b0, drop_cnt}) < (CW + 1)'(FQ_DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire   = imem_req_valid && imem_req_ready;
  assign fill       = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;

  assign inst_valid = q_head_valid || trap_show;
  assign inst_data  = q_head_valid ? q_head_data : (trap_show ? INSN_NOP : '0);
  assign inst_pc    = q_head_valid ? q_head_pc   : (trap_show ? pc       : '0);

  fetch_queue #(
    .XLEN     (XLEN),
    .FQ_DEPTH (FQ_DEPTH)
  ) u_fq (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .alloc      (req_fire),
    .alloc_pc   (pc),
    .fill       (fill),
    .fill_data  (imem_rsp_data),
    .deq        (q_deq),
    .head_valid (q_head_valid),
    .head_pc    (q_head_pc),
    .head_data  (q_head_data),
    .used       (used),
    .unfilled   (unfilled)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_BOOT: state_nx = misalign ? ST_TRAP : ST_RUN;
      ST_RUN:  if (misalign) state_nx = ST_TRAP;
      ST_TRAP: if (redirect_valid && !misalign) state_nx = ST_RUN;
      default: state_nx = ST_BOOT;
    endcase
  end

  // Every word still owed by imem for a flushed entry must be swallowed
  // before new responses are trusted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_BOOT;
      pc       <= RESET_PC;
      drop_cnt <= '0;
    end else begin
      state <= state_nx;
      if (redirect_valid) begin
        pc       <= tgt;
        drop_cnt <= drop_cnt + unfilled - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) pc <= pc + XLEN'(4);
        if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_riscv_fetch.sv
// Bench for riscv_fetch: random imem/core/redirect traffic against a
// queue-based reference model, plus directed latency, stall and redirect cases.
module tb_riscv_fetch;

  localparam int          XLEN     = 32;
  localparam int          FQ_DEPTH = 2;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        inst_misaligned;
`endif

  riscv_fetch #(.XLEN(XLEN), .RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
`ifdef FETCH_MISALIGN_CHK_EN
    , .inst_misaligned (inst_misaligned)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] data; logic mis; } exp_t;
  typedef struct { logic [31:0] addr; int cyc; } req_t;

  exp_t        expq[$];
  req_t        pend[$];
  logic [31:0] model_pc = RESET_PC;
  bit          model_trap = 1'b0;
  int          n_chk = 0, n_err = 0, n_xfer = 0, cyc = 0;
  int          rsp_pct = 100, rdy_pct = 100;
  bit          held = 1'b0;
  logic [31:0] held_pc, held_data;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    end
  endfunction

  always @(posedge clk) cyc++;

  // Instruction memory: answers in order, at least one cycle after the request.
  always @(posedge clk) begin
    #1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (pend.size() > 0 && pend[0].cyc < cyc && $urandom_range(99) < rsp_pct) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memf(pend[0].addr);
      void'(pend.pop_front());
    end
    imem_req_ready = ($urandom_range(99) < rdy_pct);
  end

  // Monitor/scoreboard: decides what the coming edge does from the settled inputs.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      expq.delete();
      pend.delete();
      model_pc   = RESET_PC;
      model_trap = 1'b0;
      held       = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", 64'(inst_valid), 64'd1);
        check("hold_pc",    64'(inst_pc),    64'(held_pc));
        check("hold_data",  64'(inst_data),  64'(held_data));
      end
      held = 1'b0;
      if (inst_valid && inst_ready) begin
        n_xfer++;
        if (expq.size() == 0) check("inst_unexpected", 64'(inst_pc), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          e = expq.pop_front();
          check("inst_pc",   64'(inst_pc),   64'(e.pc));
          check("inst_data", 64'(inst_data), 64'(e.data));
`ifdef FETCH_MISALIGN_CHK_EN
          check("inst_misaligned", 64'(inst_misaligned), 64'(e.mis));
`endif
        end
      end else if (inst_valid && !redirect_valid) begin
        held = 1'b1; held_pc = inst_pc; held_data = inst_data;
      end
      if (redirect_valid || model_trap) check("req_blocked", 64'(imem_req_valid), 64'd0);
      if (imem_req_valid && imem_req_ready) begin
        check("req_addr", 64'(imem_req_addr), 64'(model_pc));
        pend.push_back('{imem_req_addr, cyc});
        expq.push_back('{model_pc, memf(model_pc), 1'b0});
        model_pc += 32'd4;
        check("outstanding_bound", 64'(pend.size() <= FQ_DEPTH), 64'd1);
        check("queue_bound", 64'(expq.size() <= FQ_DEPTH), 64'd1);
      end
      if (redirect_valid) begin
        expq.delete();
`ifdef FETCH_MISALIGN_CHK_EN
        model_pc   = redirect_pc;
        model_trap = (redirect_pc[1:0] != 2'b00);
        if (model_trap) expq.push_back('{redirect_pc, NOP, 1'b1});
`else
        model_pc = redirect_pc & ~32'd3;
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    redirect_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_inst(input logic [31:0] want_pc, input string nm);
    bit found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (inst_valid) begin
        check(nm, 64'(inst_pc), 64'(want_pc));
        found = 1'b1;
        break;
      end
    end
    if (!found) check({nm, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    int nreq;
    int x0;
    // Reset values and fetch latency/throughput with a 1-cycle imem.
    inst_ready = 1'b1;
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_inst_data", 64'(inst_data), 64'd0);
    check("rst_inst_pc", 64'(inst_pc), 64'd0);
    check("rst_req_addr", 64'(imem_req_addr), 64'(RESET_PC));
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("boot_req_valid", 64'(imem_req_valid), 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("stream_req_valid", 64'(imem_req_valid), 64'd1);
      check("stream_req_addr", 64'(imem_req_addr), 64'(4 * i));
      check("stream_inst_valid", 64'(inst_valid), 64'(i >= 2));
      if (i >= 2) check("stream_inst_pc", 64'(inst_pc), 64'(4 * (i - 2)));
    end

    // Core stalled: only FQ_DEPTH requests go out, head held at pc 0.
    tick();
    inst_ready = 1'b0;
    reset_dut();
    nreq = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) nreq++;
    end
    check("stall_req_count", 64'(nreq), 64'(FQ_DEPTH));
    check("stall_req_valid", 64'(imem_req_valid), 64'd0);
    check("stall_head_pc", 64'(inst_pc), 64'd0);
    tick();
    inst_ready = 1'b1;
    repeat (6) tick();

    // Redirect with two requests in flight: both responses dropped.
    rsp_pct = 0;
    reset_dut();
    repeat (5) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    rsp_pct = 100;
    wait_inst(32'h100, "redirect_first_pc");

`ifdef FETCH_MISALIGN_CHK_EN
    // Misaligned redirect traps, presents one NOP, then goes quiet.
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    tick();
    redirect_valid = 1'b0;
    wait_inst(32'h102, "trap_pc");
    check("trap_misaligned", 64'(inst_misaligned), 64'd1);
    check("trap_data", 64'(inst_data), 64'(NOP));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("trap_quiet_inst", 64'(inst_valid), 64'd0);
      check("trap_quiet_req", 64'(imem_req_valid), 64'd0);
    end
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    wait_inst(32'h200, "trap_resume_pc");
`endif

    // Random traffic: stalls on both sides, redirects, rare resets, PC wrap.
    rsp_pct = 60;
    rdy_pct = 70;
    for (int i = 0; i < 4000; i++) begin
      tick();
      rst            = ($urandom_range(999) == 0);
      inst_ready     = ($urandom_range(99) < 70);
      redirect_valid = ($urandom_range(99) < 6);
      redirect_pc    = ($urandom_range(9) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'h0000_FFFF);
`ifdef FETCH_MISALIGN_CHK_EN
      if ($urandom_range(3) != 0) redirect_pc[1:0] = 2'b00;
`endif
    end

    // Final liveness: aligned redirect, everything ready, steady delivery.
    tick();
    rst = 1'b0;
    inst_ready = 1'b1;
    rsp_pct = 100;
    rdy_pct = 100;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    x0 = n_xfer;
    repeat (30) tick();
    check("liveness_xfers", 64'(n_xfer - x0 >= 20), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
